if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Fetch stage and IF/ID pipeline register; sits directly upstream of the decode/writeback stage.
//  Owns the PC and drives the instruction-memory address.
//  Selects next PC by priority: exception vector, EPC (ERET), D-stage branch/jump target, PC+4.
//  Registers IR_D, PC4_D, PC_D, delay-slot flag and fetch exception code for decode.
// PARAMETERS
//  RESET_PC     32'h0000_3000  PC value after reset
//  IM_BASE      32'h0000_3000  first byte address of instruction memory
//  IM_WORDS     4096           instruction memory depth in 32-bit words
//  EXC_VECTOR   32'h0000_4180  exception/interrupt handler entry
// PORTS
//  clk          in   1   single clock; all state updates on rising edge
//  reset        in   1   asynchronous, active-low; 0 clears all state immediately
//  stall_d      in   1   hazard unit: hold PC and IF/ID this cycle
//  pc_sel       in   1   D-stage branch taken / jump (from decode control)
//  b_j_jr_tgt   in   32  D-stage computed branch/jump/jr target
//  eret_pc_sel  in   1   ERET resident in D
//  epc          in   32  CP0 EPC, forwarded value
//  exc_req      in   1   CP0 exception/interrupt commit: redirect and flush
//  imem_addr    out  32  word-aligned fetch address = PC (combinational read memory)
//  imem_rdata   in   32  instruction at imem_addr, same cycle
//  pc_f         out  32  current fetch PC (for CP0 EPC capture on fetch faults)
//  IR_D         out  32  registered instruction to decode
//  PC4_D        out  32  registered PC+4 of that instruction
//  PC_D         out  32  registered PC of that instruction
//  BD_D         out  1   instruction in D sits in a branch delay slot
//  EXC_D        out  5   fetch exception code: 0 none, 4 AdEL
// BEHAVIOUR
//  Reset (reset=0, async): PC=RESET_PC; IR_D=0 (nop); PC4_D=RESET_PC+4; PC_D=RESET_PC; BD_D=0; EXC_D=0.
//   Release is sampled at the next rising edge. Reset mid-stall or mid-redirect discards all pending redirects.
//  Fetch fault: PC[1:0]!=0, or PC outside [IM_BASE, IM_BASE+4*IM_WORDS) -> fetched word replaced by 0 (nop),
//   EXC_D<=4 with the faulting PC in PC_D; imem_addr still driven (its data is ignored).
//  Delay-slot detect: bd_f = IR_D is beq/bne/blez/bgtz/bltz/bgez/j/jal/jr/jalr; BD_D<=bd_f on each load.
//  Next-state priority per edge (highest first):
//   1 exc_req     : PC<=EXC_VECTOR; IF/ID<=nop (IR=0,EXC=0,BD=0, PC_D/PC4_D<=PC_D/PC4_D held). Overrides stall.
//   2 stall_d     : PC and all IF/ID fields hold. pc_sel and eret_pc_sel are ignored (resampled after stall drops).
//   3 eret_pc_sel : PC<=epc; IF/ID<=nop (no delay slot for ERET; the PC+4 fetch is killed).
//   4 pc_sel      : PC<=b_j_jr_tgt; IF/ID<=fetched word (delay slot executes, BD_D=1).
//   5 default     : PC<=PC+4; IF/ID<=fetched word.
//  eret_pc_sel and pc_sel both high: eret wins (decode never asserts both; do not assert).
//  Latency: instruction at PC appears on IR_D one edge after PC presents it; redirect costs 0 bubbles for
//   branches (delay slot), 1 bubble for ERET and exception.
//  PC arithmetic is 32-bit modulo; PC+4 at 32'hFFFF_FFFC wraps to 0 (then faults as out-of-range).
//  epc / b_j_jr_tgt are loaded unaligned as given; the fault is flagged on that fetch, not on the load.
// STRUCTURE
//  Shared package: RESET_PC/EXC_VECTOR/IM_BASE constants, EXC code enum (EXC_NONE=0, EXC_ADEL=4),
//   opcode/funct constants for branch/jump decode (shared with decode control).
//  One sub-module: if_bd_detect (combinational branch/jump classifier of IR_D) reused by CP0 logic.
//  PC register and IF/ID register kept in this module; next-PC mux is inline.
// TESTING
//  Reset low mid-run, release -> pc_f=0x3000; after edge IR_D=mem[0], PC4_D=0x3004, EXC_D=0.
//  Straight-line 3 fetches -> pc_f 0x3000,0x3004,0x3008; IR_D tracks each word one edge later.
//  beq taken in D (pc_sel=1, tgt=0x3040) -> next IR_D = delay-slot word with BD_D=1, then pc_f=0x3040.
//  stall_d=1 for 2 cycles with pc_sel=1 -> PC/IR_D frozen; redirect takes effect on first unstalled edge.
//  eret_pc_sel=1, epc=0x3100 -> IR_D=0, pc_f=0x3100; with stall_d=1 simultaneously -> nothing changes.
//  jr to 0x3002, then exc_req with stall_d=1 -> EXC_D=4, PC_D=0x3002; then pc_f=0x4180, IR_D=0.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared fetch-stage constants: memory map, exception codes, branch/jump opcodes, IF/ID payload.
package if_stage_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned EXC_W    = 5;
  localparam int unsigned OP_W     = 6;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned IM_WORDS = 4096;

  localparam logic [XLEN-1:0] RESET_PC   = 32'h0000_3000;
  localparam logic [XLEN-1:0] IM_BASE    = 32'h0000_3000;
  localparam logic [XLEN-1:0] EXC_VECTOR = 32'h0000_4180;
  localparam logic [XLEN-1:0] IM_LIMIT   = IM_BASE + 32'(4 * IM_WORDS);

  typedef enum logic [EXC_W-1:0] {
    EXC_NONE = 5'd0,
    EXC_ADEL = 5'd4
  } exc_code_e;

  localparam logic [OP_W-1:0] OP_SPECIAL = 6'h00;
  localparam logic [OP_W-1:0] OP_REGIMM  = 6'h01;
  localparam logic [OP_W-1:0] OP_J       = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL     = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ     = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE     = 6'h05;
  localparam logic [OP_W-1:0] OP_BLEZ    = 6'h06;
  localparam logic [OP_W-1:0] OP_BGTZ    = 6'h07;
  localparam logic [OP_W-1:0] FN_JR      = 6'h08;
  localparam logic [OP_W-1:0] FN_JALR    = 6'h09;
  localparam logic [REG_W-1:0] RT_BLTZ   = 5'h00;
  localparam logic [REG_W-1:0] RT_BGEZ   = 5'h01;

  typedef struct packed {
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] pc;
    logic            bd;
    exc_code_e       exc;
  } ifid_t;

endpackage

// File: rtl/if_bd_detect.sv
// Classifies an instruction as a branch/jump, i.e. whether the next fetched word is a delay slot.
module if_bd_detect
  import if_stage_pkg::*;
(
  input  logic [OP_W-1:0]  opcode,
  input  logic [REG_W-1:0] rt,
  input  logic [OP_W-1:0]  funct,
  output logic             is_bd_c
);

  always_comb begin
    is_bd_c = 1'b0;
    case (opcode)
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_J, OP_JAL: is_bd_c = 1'b1;
      OP_REGIMM:  is_bd_c = (rt == RT_BLTZ) || (rt == RT_BGEZ);
      OP_SPECIAL: is_bd_c = (funct == FN_JR) || (funct == FN_JALR);
      default:    is_bd_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// Fetch stage: owns the PC, selects the next PC and loads the IF/ID pipeline register.
module if_stage
  import if_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_d,
  input  logic              pc_sel,
  input  logic [XLEN-1:0]   b_j_jr_tgt,
  input  logic              eret_pc_sel,
  input  logic [XLEN-1:0]   epc,
  input  logic              exc_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic [XLEN-1:0]   imem_rdata,
  output logic [XLEN-1:0]   pc_f,
  output logic [XLEN-1:0]   IR_D,
  output logic [XLEN-1:0]   PC4_D,
  output logic [XLEN-1:0]   PC_D,
  output logic              BD_D,
  output logic [EXC_W-1:0]  EXC_D
);

  logic [XLEN-1:0] pc_q, pc_d;
  ifid_t           ifid_q, ifid_d;
  ifid_t           fetch_c;
  ifid_t           nop_c;
  logic            bd_f_c;
  logic            fetch_fault_c;

  if_bd_detect u_bd_detect (
    .opcode  (ifid_q.ir[31:26]),
    .rt      (ifid_q.ir[20:16]),
    .funct   (ifid_q.ir[5:0]),
    .is_bd_c (bd_f_c)
  );

  // Misaligned or out-of-window fetches become a nop tagged AdEL.
  always_comb begin
    fetch_fault_c = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || (pc_q >= IM_LIMIT);
    fetch_c.ir    = imem_rdata;
    fetch_c.pc4   = pc_q + 32'd4;
    fetch_c.pc    = pc_q;
    fetch_c.bd    = bd_f_c;
    fetch_c.exc   = EXC_NONE;
    if (fetch_fault_c) begin
      fetch_c.ir  = '0;
      fetch_c.exc = EXC_ADEL;
    end
  end

  // Bubble keeps the old PC_D/PC4_D so CP0 still sees a sensible address.
  always_comb begin
    nop_c     = ifid_q;
    nop_c.ir  = '0;
    nop_c.bd  = 1'b0;
    nop_c.exc = EXC_NONE;
  end

  always_comb begin
    pc_d   = pc_q;
    ifid_d = ifid_q;
    if (exc_req) begin
      pc_d   = EXC_VECTOR;
      ifid_d = nop_c;
    end else if (stall_d) begin
      pc_d   = pc_q;
      ifid_d = ifid_q;
    end else if (eret_pc_sel) begin
      pc_d   = epc;
      ifid_d = nop_c;
    end else if (pc_sel) begin
      pc_d   = b_j_jr_tgt;
      ifid_d = fetch_c;
    end else begin
      pc_d   = fetch_c.pc4;
      ifid_d = fetch_c;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      ifid_q.ir  <= '0;
      ifid_q.pc4 <= RESET_PC + 32'd4;
      ifid_q.pc  <= RESET_PC;
      ifid_q.bd  <= 1'b0;
      ifid_q.exc <= EXC_NONE;
    end else begin
      pc_q   <= pc_d;
      ifid_q <= ifid_d;
    end
  end

  assign imem_addr = pc_q;
  assign pc_f      = pc_q;
  assign IR_D      = ifid_q.ir;
  assign PC4_D     = ifid_q.pc4;
  assign PC_D      = ifid_q.pc;
  assign BD_D      = ifid_q.bd;
  assign EXC_D     = ifid_q.exc;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, straight-line fetch, branches, stalls, ERET, faults, exceptions.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_d, pc_sel, eret_pc_sel, exc_req;
  logic [31:0] b_j_jr_tgt, epc;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] pc_f, IR_D, PC4_D, PC_D;
  logic        BD_D;
  logic [4:0]  EXC_D;

  logic [31:0] mem [4096];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk         (clk),
    .reset       (reset),
    .stall_d     (stall_d),
    .pc_sel      (pc_sel),
    .b_j_jr_tgt  (b_j_jr_tgt),
    .eret_pc_sel (eret_pc_sel),
    .epc         (epc),
    .exc_req     (exc_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .pc_f        (pc_f),
    .IR_D        (IR_D),
    .PC4_D       (PC4_D),
    .PC_D        (PC_D),
    .BD_D        (BD_D),
    .EXC_D       (EXC_D)
  );

  // Combinational instruction memory; out-of-window reads return junk the DUT must discard.
  always_comb begin
    logic [31:0] off;
    off = imem_addr - 32'h0000_3000;
    if (imem_addr >= 32'h0000_3000 && imem_addr < 32'h0000_7000)
      imem_rdata = mem[off[13:2]];
    else
      imem_rdata = 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_d(input string tag, input logic [31:0] pc, input logic [31:0] ir,
                         input logic [31:0] pcd, input logic bd, input logic [4:0] exc);
    check({tag, ".pc_f"}, pc_f, pc);
    check({tag, ".IR_D"}, IR_D, ir);
    check({tag, ".PC_D"}, PC_D, pcd);
    check({tag, ".PC4_D"}, PC4_D, pcd + 32'd4);
    check({tag, ".BD_D"}, 32'(BD_D), 32'(bd));
    check({tag, ".EXC_D"}, 32'(EXC_D), 32'(exc));
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h2400_0000 | 32'(i);
    mem[3]  = 32'h1000_0010;   // beq
    mem[16] = 32'h0800_0000;   // j
    mem[65] = 32'h03E0_0008;   // jr $ra

    reset = 1'b0; stall_d = 1'b0; pc_sel = 1'b0; eret_pc_sel = 1'b0; exc_req = 1'b0;
    b_j_jr_tgt = '0; epc = '0;

    repeat (2) @(posedge clk);
    #3;
    check_d("reset", 32'h3000, 32'h0, 32'h3000, 1'b0, 5'd0);
    reset = 1'b1;

    // Straight-line fetch
    step(); check_d("seq0", 32'h3004, mem[0], 32'h3000, 1'b0, 5'd0);
    step(); check_d("seq1", 32'h3008, mem[1], 32'h3004, 1'b0, 5'd0);
    step(); check_d("seq2", 32'h300C, mem[2], 32'h3008, 1'b0, 5'd0);
    step(); check_d("beq_in_d", 32'h3010, mem[3], 32'h300C, 1'b0, 5'd0);

    // Taken beq: delay slot still loads, flagged BD
    pc_sel = 1'b1; b_j_jr_tgt = 32'h3040;
    step(); check_d("delay_slot", 32'h3040, mem[4], 32'h3010, 1'b1, 5'd0);
    pc_sel = 1'b0;
    step(); check_d("at_tgt", 32'h3044, mem[16], 32'h3040, 1'b0, 5'd0);

    // Stall with pending jump redirect
    stall_d = 1'b1; pc_sel = 1'b1; b_j_jr_tgt = 32'h3080;
    step(); check_d("stall1", 32'h3044, mem[16], 32'h3040, 1'b0, 5'd0);
    step(); check_d("stall2", 32'h3044, mem[16], 32'h3040, 1'b0, 5'd0);
    stall_d = 1'b0;
    step(); check_d("unstall_j", 32'h3080, mem[17], 32'h3044, 1'b1, 5'd0);
    pc_sel = 1'b0;

    // ERET blocked by stall, then taken with a bubble
    eret_pc_sel = 1'b1; epc = 32'h3100; stall_d = 1'b1;
    step(); check_d("eret_stall", 32'h3080, mem[17], 32'h3044, 1'b1, 5'd0);
    stall_d = 1'b0;
    step(); check_d("eret", 32'h3100, 32'h0, 32'h3044, 1'b0, 5'd0);
    eret_pc_sel = 1'b0;
    step(); check_d("after_eret", 32'h3104, mem[64], 32'h3100, 1'b0, 5'd0);

    // jr to a misaligned target, fault, then exception over a stall
    step(); check_d("jr_in_d", 32'h3108, mem[65], 32'h3104, 1'b0, 5'd0);
    pc_sel = 1'b1; b_j_jr_tgt = 32'h3002;
    step(); check_d("jr_slot", 32'h3002, mem[66], 32'h3108, 1'b1, 5'd0);
    pc_sel = 1'b0;
    step(); check_d("adel_misalign", 32'h3006, 32'h0, 32'h3002, 1'b0, 5'd4);
    exc_req = 1'b1; stall_d = 1'b1;
    step(); check_d("exc", 32'h4180, 32'h0, 32'h3002, 1'b0, 5'd0);
    exc_req = 1'b0; stall_d = 1'b0;
    step(); check_d("handler", 32'h4184, mem[1120], 32'h4180, 1'b0, 5'd0);

    // Last word of memory, then first out-of-range address
    pc_sel = 1'b1; b_j_jr_tgt = 32'h6FFC;
    step(); check_d("to_top", 32'h6FFC, mem[1121], 32'h4184, 1'b0, 5'd0);
    pc_sel = 1'b0;
    step(); check_d("last_word", 32'h7000, mem[4095], 32'h6FFC, 1'b0, 5'd0);
    step(); check_d("adel_range", 32'h7004, 32'h0, 32'h7000, 1'b0, 5'd4);

    // PC+4 wrap at the top of the address space
    eret_pc_sel = 1'b1; epc = 32'hFFFF_FFFC;
    step(); check("wrap_eret.pc_f", pc_f, 32'hFFFF_FFFC);
    eret_pc_sel = 1'b0;
    step(); check_d("wrap", 32'h0, 32'h0, 32'hFFFF_FFFC, 1'b0, 5'd4);

    // Asynchronous reset mid-stall with a redirect pending
    stall_d = 1'b1; pc_sel = 1'b1; b_j_jr_tgt = 32'h3200;
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check_d("async_rst", 32'h3000, 32'h0, 32'h3000, 1'b0, 5'd0);
    stall_d = 1'b0; pc_sel = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step(); check_d("post_rst", 32'h3004, mem[0], 32'h3000, 1'b0, 5'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
